// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_if
//  Description : Byte-stream receive handshake and program-memory write port
//                used by program_loader.
//                  rx_data   [7:0]        stream byte (master -> loader)
//                  rx_valid               rx_data valid (master -> loader)
//                  rx_ready               loader accepts a byte (loader -> master)
//                  mem_we                 program memory write strobe
//                  mem_addr  [ADDR_W-1:0] program memory write address
//                  mem_wdata [15:0]       instruction word {opcode, operand}
//                The master modport is the host/memory side; the slave
//                modport is the loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Boot-time program loader for the accumulator CPU. Receives
//                a byte stream (2-byte big-endian word count N, then N words
//                high byte first), rejects illegal opcodes (0x8-0xF), writes
//                the words to consecutive program-memory addresses and holds
//                the CPU stopped until a complete, legal program is loaded.
//  Ports       : clk            system clock, rising edge
//                rst_n          asynchronous active-low reset
//                start          one-cycle load request (IDLE/DONE/ERROR only)
//                bus            byte handshake + memory write port (slave)
//                busy           load in progress (LEN_HI .. WRITE)
//                done           load completed successfully
//                err_opcode     illegal opcode seen (sticky until start)
//                err_len        word count exceeds 2^ADDR_W (sticky)
//                cpu_run        CPU release, high only in DONE
//                words_loaded   words written by the current load
//  Parameters  : ADDR_W         program memory address width (1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  program_loader_if.slave        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err_opcode,
  output logic                   err_len,
  output logic                   cpu_run,
  output logic [ADDR_W:0]        words_loaded
);

  // Largest legal word count: the whole program memory.
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_INS_HI = 3'd3,
    S_INS_LO = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t            state_q,      state_d;
  logic [15:0]       len_q,        len_d;
  logic [7:0]        ins_hi_q,     ins_hi_d;
  logic [7:0]        ins_lo_q,     ins_lo_d;
  logic [ADDR_W:0]   words_q,      words_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_len_q,    err_len_d;

  logic              rx_ready_w;
  logic              xfer_w;
  logic [15:0]       len_full_w;
  logic              last_word_w;

  // --------------------------------------------------------------------------
  // Moore decode of the handshake ready; a byte moves only when both agree.
  // --------------------------------------------------------------------------
  assign rx_ready_w = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_INS_HI) || (state_q == S_INS_LO);
  assign xfer_w     = bus.rx_valid && rx_ready_w;

  // Complete word count as seen during the LEN_LO transfer.
  assign len_full_w = {len_q[15:8], bus.rx_data};

  // The word being written in WRITE is the final one of the program.
  assign last_word_w = ((17'(words_q) + 17'd1) == {1'b0, len_q});

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    ins_hi_d     = ins_hi_q;
    ins_lo_d     = ins_lo_q;
    words_d      = words_q;
    err_opcode_d = err_opcode_q;
    err_len_d    = err_len_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          words_d      = '0;
          err_opcode_d = 1'b0;
          err_len_d    = 1'b0;
        end
      end

      S_LEN_HI: begin
        if (xfer_w) begin
          len_d   = {bus.rx_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (xfer_w) begin
          len_d = len_full_w;
          if (len_full_w == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_full_w} > MAX_LEN) begin
            state_d   = S_ERROR;
            err_len_d = 1'b1;
          end else begin
            state_d = S_INS_HI;
          end
        end
      end

      S_INS_HI: begin
        if (xfer_w) begin
          // Legal opcodes are 0x0-0x7, so bit 7 of the high byte flags
          // an illegal one. The word is dropped, nothing is written.
          if (bus.rx_data[7]) begin
            state_d      = S_ERROR;
            err_opcode_d = 1'b1;
          end else begin
            ins_hi_d = bus.rx_data;
            state_d  = S_INS_LO;
          end
        end
      end

      S_INS_LO: begin
        if (xfer_w) begin
          ins_lo_d = bus.rx_data;
          state_d  = S_WRITE;
        end
      end

      S_WRITE: begin
        words_d = words_q + 1'b1;
        state_d = last_word_w ? S_DONE : S_INS_HI;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      ins_hi_q     <= '0;
      ins_lo_q     <= '0;
      words_q      <= '0;
      err_opcode_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ins_hi_q     <= ins_hi_d;
      ins_lo_q     <= ins_lo_d;
      words_q      <= words_d;
      err_opcode_q <= err_opcode_d;
      err_len_q    <= err_len_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state so an asynchronous reset
  // forces every one of them low in the same cycle. Address and data are
  // held at zero outside WRITE so the write port is quiet between words.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.rx_ready  = rx_ready_w;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    cpu_run       = 1'b0;

    if (state_q == S_WRITE) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = words_q[ADDR_W-1:0];
      bus.mem_wdata = {ins_hi_q, ins_lo_q};
    end

    if (rx_ready_w || (state_q == S_WRITE)) begin
      busy = 1'b1;
    end

    if (state_q == S_DONE) begin
      done    = 1'b1;
      cpu_run = 1'b1;
    end
  end

  assign err_opcode   = err_opcode_q;
  assign err_len      = err_len_q;
  assign words_loaded = words_q;

endmodule
`default_nettype wire
